// File: rtl/minha_memoria_512.sv
// 512 x 16 RAM with sync write/clear and zero-latency combinational read on a shared address.
// Latency: read 0 cycles; write visible right after the edge. Backpressure: none, one write per edge.
// Optional MINHA_MEMORIA_512_BYPASS_EN: a word being written is shown on valor_saida before the edge.
module minha_memoria_512 #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  sinal_clock,
  input  logic                  sinal_reset,
  input  logic [DATA_WIDTH-1:0] valor_entrada,
  input  logic [ADDR_WIDTH-1:0] posicao_mem,
  input  logic                  enable_write,
  output logic [DATA_WIDTH-1:0] valor_saida
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] stored_dat;

  // Reset clears every word and wins over a write in the same cycle.
  always_ff @(posedge sinal_clock) begin
    if (sinal_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (enable_write) begin
      mem[posicao_mem] <= valor_entrada;
    end
  end

  assign stored_dat = mem[posicao_mem];

`ifdef MINHA_MEMORIA_512_BYPASS_EN
  assign valor_saida = (enable_write && !sinal_reset) ? valor_entrada : stored_dat;
`else
  assign valor_saida = stored_dat;
`endif

endmodule

// File: tb/tb_minha_memoria_512.sv
// Self-checking bench for minha_memoria_512: directed cases plus a randomized phase against an array model.
module tb_minha_memoria_512;

  logic        sinal_clock;
  logic        sinal_reset;
  logic [15:0] valor_entrada;
  logic [8:0]  posicao_mem;
  logic        enable_write;
  logic [15:0] valor_saida;

  int total;
  int bad;
  logic [15:0] model [512];

  minha_memoria_512 dut (
    .sinal_clock  (sinal_clock),
    .sinal_reset  (sinal_reset),
    .valor_entrada(valor_entrada),
    .posicao_mem  (posicao_mem),
    .enable_write (enable_write),
    .valor_saida  (valor_saida)
  );

  initial sinal_clock = 1'b0;
  always #5 sinal_clock = ~sinal_clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Combinational read: no clock needed, sampled 1 time unit after the address settles.
  task automatic read_check(input string tag, input logic [8:0] addr);
    enable_write = 1'b0;
    sinal_reset  = 1'b0;
    posicao_mem  = addr;
    #1;
    check(tag, valor_saida, model[addr]);
  endtask

  // Value visible on valor_saida while a write is pending but before its edge.
  function automatic logic [15:0] pending_view(input logic [8:0] addr, input logic [15:0] dat,
                                               input logic we, input logic rst);
`ifdef MINHA_MEMORIA_512_BYPASS_EN
    if (we && !rst) return dat;
`endif
    return model[addr];
  endfunction

  task automatic cycle(input logic rst, input logic we, input logic [8:0] addr,
                       input logic [15:0] dat, input string tag);
    @(negedge sinal_clock);
    sinal_reset   = rst;
    enable_write  = we;
    posicao_mem   = addr;
    valor_entrada = dat;
    #1;
    check({tag, "_pre"}, valor_saida, pending_view(addr, dat, we, rst));
    @(posedge sinal_clock);
    if (rst) begin
      for (int i = 0; i < 512; i++) model[i] = 16'h0000;
    end else if (we) begin
      model[addr] = dat;
    end
    #1;
    sinal_reset  = 1'b0;
    enable_write = 1'b0;
  endtask

  initial begin
    logic [8:0]  waddr [6];
    logic [15:0] wdat  [6];
    total = 0;
    bad   = 0;
    sinal_reset   = 1'b1;
    enable_write  = 1'b0;
    valor_entrada = 16'h0000;
    posicao_mem   = 9'd0;

    // Initial reset; the pre-edge view is undefined so sample only afterwards.
    @(posedge sinal_clock);
    for (int i = 0; i < 512; i++) model[i] = 16'h0000;
    #1;
    sinal_reset = 1'b0;
    read_check("rst_a0", 9'd0);
    read_check("rst_a255", 9'd255);
    read_check("rst_a511", 9'd511);

    waddr = '{9'd0, 9'd1, 9'd2, 9'd3, 9'd500, 9'd511};
    wdat  = '{16'hAAAA, 16'h5555, 16'hF0F0, 16'h0F0F, 16'hA5A5, 16'h5A5A};
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, waddr[i], wdat[i], "wr_pattern");
    for (int i = 0; i < 6; i++) read_check("rd_pattern", waddr[i]);
    check("pattern_a511_const", model[511] === 16'h5A5A ? valor_saida : 16'hxxxx, 16'h5A5A);

    cycle(1'b0, 1'b0, 9'd0, 16'hFFFF, "hold1");
    cycle(1'b0, 1'b0, 9'd0, 16'hFFFF, "hold2");
    posicao_mem = 9'd0;
    #1;
    check("hold_a0", valor_saida, 16'hAAAA);

    cycle(1'b0, 1'b1, 9'd0, 16'hFFFF, "overwrite");
    posicao_mem = 9'd0;
    #1;
    check("overwrite_a0", valor_saida, 16'hFFFF);
    read_check("overwrite_a1", 9'd1);
    read_check("overwrite_a511", 9'd511);

    cycle(1'b0, 1'b1, 9'd300, 16'h7777, "pre300");
    cycle(1'b0, 1'b1, 9'd300, 16'hCCCC, "bypass300");
    read_check("after300", 9'd300);

    // Reset colliding with a write: the write is dropped, everything reads 0.
    cycle(1'b1, 1'b1, 9'd100, 16'h1234, "rst_wr");
    posicao_mem = 9'd100;
    #1;
    check("rst_wr_a100", valor_saida, 16'h0000);
    for (int i = 0; i < 512; i++) read_check("rst_sweep", 9'(i));

    cycle(1'b0, 1'b1, 9'd100, 16'h4321, "post_rst_wr");
    read_check("post_rst_a100", 9'd100);

    // Randomized phase with back-to-back writes, hot-spot addresses and a mid-stream reset.
    for (int n = 0; n < 400; n++) begin
      logic [8:0]  a;
      logic [15:0] d;
      logic        we;
      logic        rst;
      a   = (n % 5 == 0) ? 9'($urandom_range(0, 3) + 508) : 9'($urandom_range(0, 511));
      d   = 16'($urandom);
      we  = ($urandom_range(0, 3) != 0);
      rst = (n == 200);
      cycle(rst, we, a, d, "rnd");
      read_check("rnd_same", a);
      read_check("rnd_any", 9'($urandom_range(0, 511)));
    end
    for (int i = 0; i < 512; i++) read_check("final_sweep", 9'(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
